// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a request-to-send,
// then shifts out data/parity/stop on device falling edges and checks the device ACK.
//
// state   | meaning
// IDLE    | bus released, waiting for send_command_en
// INHIBIT | host holds PS2_CLK low; PS2_DAT pulled low in the last cycle
// REQ     | clock released, start bit on the line, waiting for the first device edge
// BITS    | data[0..7], parity and stop shifted out one per device falling edge
// ACK     | waiting for the falling edge that carries the device acknowledge
// DONE    | one-cycle command_was_sent pulse
// ERR     | one-cycle error_timed_out pulse (timeout or NACK)
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] send_command,
    input  logic       send_command_en,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timed_out
);

    localparam int MAX_A   = (INHIBIT_CYCLES > XFER_TIMEOUT) ? INHIBIT_CYCLES : XFER_TIMEOUT;
    localparam int MAX_CNT = (START_TIMEOUT > MAX_A) ? START_TIMEOUT : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LOAD    = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_BITS    = 3'd3,
        ST_ACK     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [9:0]       frame_q,    frame_d;
    logic             dat_drv_q,  dat_drv_d;
    logic             clk_meta_q, clk_meta_d;
    logic             clk_sync_q, clk_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic             dat_meta_q, dat_meta_d;
    logic             dat_sync_q, dat_sync_d;
    logic             fe;

    assign fe = clk_prev_q & ~clk_sync_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            dat_drv_q  <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            dat_drv_q  <= dat_drv_d;
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            clk_prev_q <= clk_prev_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bit_cnt_d        = bit_cnt_q;
        frame_d          = frame_q;
        dat_drv_d        = dat_drv_q;
        clk_meta_d       = ps2_clk_in;
        clk_sync_d       = clk_meta_q;
        clk_prev_d       = clk_sync_q;
        dat_meta_d       = ps2_dat_in;
        dat_sync_d       = dat_meta_q;
        ps2_clk_oe       = 1'b0;
        ps2_dat_oe       = 1'b0;
        busy             = 1'b0;
        command_was_sent = 1'b0;
        error_timed_out  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send_command_en) begin
                    // Frame shifts out LSB first: data[0..7], odd parity, stop.
                    frame_d   = {1'b1, ~^send_command, send_command};
                    cnt_d     = INHIBIT_LOAD;
                    bit_cnt_d = '0;
                    dat_drv_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                busy       = 1'b1;
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = (cnt_q == CNT_ZERO);
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = START_LOAD;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_REQ: begin
                busy       = 1'b1;
                ps2_dat_oe = 1'b1;
                if (fe) begin
                    dat_drv_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_cnt_d = 4'd1;
                    cnt_d     = XFER_LOAD;
                    state_d   = ST_BITS;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_BITS: begin
                busy       = 1'b1;
                ps2_dat_oe = dat_drv_q;
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (fe) begin
                        dat_drv_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = ST_ACK;
                        end
                    end
                end
            end

            ST_ACK: begin
                busy = 1'b1;
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (fe) begin
                        state_d = dat_sync_q ? ST_ERR : ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                command_was_sent = 1'b1;
                cnt_d            = '0;
                dat_drv_d        = 1'b0;
                state_d          = ST_IDLE;
            end

            ST_ERR: begin
                error_timed_out = 1'b1;
                cnt_d           = '0;
                dat_drv_d       = 1'b0;
                state_d         = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx: a simple PS/2 device model clocks frames out of the DUT
// and every scenario task compares sampled bits, pulses and timings against hand values.
module tb_ps2_command_tx;

    localparam int INH  = 50;
    localparam int STO  = 400;
    localparam int XTO  = 3000;
    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] send_command    = 8'h00;
    logic       send_command_en = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_timed_out;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          cyc_cnt  = 0;
    logic [10:0] dev_bits;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_command_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .send_command     (send_command),
        .send_command_en  (send_command_en),
        .ps2_clk_in       (ps2_clk_in),
        .ps2_dat_in       (ps2_dat_in),
        .ps2_clk_oe       (ps2_clk_oe),
        .ps2_dat_oe       (ps2_dat_oe),
        .busy             (busy),
        .command_was_sent (command_was_sent),
        .error_timed_out  (error_timed_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        cyc_cnt++;
        if (command_was_sent === 1'b1) done_cnt++;
        if (error_timed_out === 1'b1) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Strobe a request, then count inhibit cycles; returns in the first REQ cycle.
    task automatic start_request(input logic [7:0] cmd, output int inh, output int dat_last);
        @(posedge CLOCK_50);
        #1;
        send_command    = cmd;
        send_command_en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        send_command_en = 1'b0;
        inh      = 0;
        dat_last = 0;
        while (ps2_clk_oe === 1'b1 && inh < INH + 100) begin
            inh++;
            if (ps2_dat_oe === 1'b1) dat_last++;
            cyc(1);
        end
    endtask

    // Device clock pulses first..last; the bus is sampled while the clock is high.
    task automatic dev_clocks(input int first, input int last, input logic nack);
        for (int k = first; k <= last; k++) begin
            cyc(HALF);
            dev_bits[k] = ps2_dat_in;
            if (k == 10) dev_dat = nack;
            cyc(3);
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
        end
        if (last == 10) begin
            cyc(2);
            dev_dat = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(3);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_timed_out} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_timed_out});
        end
        resetn = 1'b1;
        cyc(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_send(input string name, input logic [7:0] cmd, input logic [10:0] exp_bits);
        int inh, dl, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        dev_bits = '0;
        start_request(cmd, inh, dl);
        checks++;
        if (inh !== INH) begin
            failures++;
            $display("FAIL %s inhibit_len got=%0d exp=%0d", name, inh, INH);
        end
        checks++;
        if (dl !== 1) begin
            failures++;
            $display("FAIL %s inhibit_dat_cycles got=%0d exp=1", name, dl);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b011) begin
            failures++;
            $display("FAIL %s req_outputs got=%b exp=011", name, {ps2_clk_oe, ps2_dat_oe, busy});
        end
        dev_clocks(0, 10, 1'b0);
        cyc(5);
        checks++;
        if (dev_bits !== exp_bits) begin
            failures++;
            $display("FAIL %s frame_bits got=%b exp=%b", name, dev_bits, exp_bits);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL %s sent_pulses got=%0d exp=1", name, done_cnt - d0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL %s err_pulses got=%0d exp=0", name, err_cnt - e0);
        end
        checks++;
        if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin
            failures++;
            $display("FAIL %s end_idle got=%b exp=000", name, {busy, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_start_timeout();
        int inh, dl, n, e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        start_request(8'hED, inh, dl);
        n = 0;
        while (error_timed_out !== 1'b1 && n < STO + 50) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n !== STO) begin
            failures++;
            $display("FAIL start_timeout cycles got=%0d exp=%0d", n, STO);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL start_timeout_oe got=%b exp=000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        cyc(1);
        checks++;
        if (error_timed_out !== 1'b0 || err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL start_timeout_pulse got err=%b errs=%0d dones=%0d exp err=0 errs=1 dones=0",
                     error_timed_out, err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_nack();
        int inh, dl, e0, d0;
        e0 = err_cnt;
        d0 = done_cnt;
        dev_bits = '0;
        start_request(8'h12, inh, dl);
        dev_clocks(0, 10, 1'b1);
        cyc(5);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL nack_err got=%0d exp=1", err_cnt - e0);
        end
        checks++;
        if (done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL nack_sent got=%0d exp=0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int inh, dl;
        dev_bits = '0;
        start_request(8'hAA, inh, dl);
        dev_clocks(0, 4, 1'b0);
        cyc(2);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b011) begin
            failures++;
            $display("FAIL midframe_bit4 got=%b exp=011", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_release got=%b exp=000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        cyc(2);
        resetn = 1'b1;
        test_send("after_reset_F4", 8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0});
    endtask

    task automatic test_ignore_in_bits();
        int inh, dl, d0;
        d0 = done_cnt;
        dev_bits = '0;
        start_request(8'hC3, inh, dl);
        dev_clocks(0, 3, 1'b0);
        send_command    = 8'h55;
        send_command_en = 1'b1;
        cyc(1);
        send_command_en = 1'b0;
        send_command    = 8'h00;
        dev_clocks(4, 10, 1'b0);
        cyc(5);
        checks++;
        if (dev_bits !== {1'b1, 1'b1, 8'hC3, 1'b0}) begin
            failures++;
            $display("FAIL ignore_bits got=%b exp=%b", dev_bits, {1'b1, 1'b1, 8'hC3, 1'b0});
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL ignore_sent got=%0d exp=1", done_cnt - d0);
        end
        cyc(10);
        checks++;
        if ({busy, ps2_clk_oe} !== 2'b00) begin
            failures++;
            $display("FAIL ignore_no_restart got=%b exp=00", {busy, ps2_clk_oe});
        end
    endtask

    task automatic test_xfer_timeout();
        int inh, dl, c0, n, e0;
        e0 = err_cnt;
        start_request(8'h0F, inh, dl);
        c0 = cyc_cnt;
        dev_clocks(0, 2, 1'b0);
        n = 0;
        while (error_timed_out !== 1'b1 && n < XTO + 200) begin
            cyc(1);
            n++;
        end
        checks++;
        if (cyc_cnt - c0 !== 26 + XTO) begin
            failures++;
            $display("FAIL xfer_timeout cycles got=%0d exp=%0d", cyc_cnt - c0, 26 + XTO);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            failures++;
            $display("FAIL xfer_timeout_oe got=%b exp=000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
        cyc(1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL xfer_timeout_pulses got=%0d exp=1", err_cnt - e0);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_send("send_ED", 8'hED, {1'b1, 1'b1, 8'hED, 1'b0});
        test_send("send_00", 8'h00, {1'b1, 1'b1, 8'h00, 1'b0});
        test_start_timeout();
        test_nack();
        test_reset_mid_frame();
        test_ignore_in_bits();
        test_xfer_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
